// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared encodings for the multi-cycle RV32I control unit:
//               FSM states, opcodes, ALU operations and datapath mux selects.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // Controller states, one per datapath micro-step
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_JALR_PC   = 4'd12,
        S_LUI       = 4'd13
    } state_t;

    // Opcodes (instruction[6:0])
    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;

    // ALU operations
    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_XOR = 3'b100;
    localparam logic [2:0] C_ALU_SLT = 3'b101;

    // Immediate formats
    localparam logic [2:0] C_IMM_I = 3'b000;
    localparam logic [2:0] C_IMM_S = 3'b001;
    localparam logic [2:0] C_IMM_B = 3'b010;
    localparam logic [2:0] C_IMM_J = 3'b011;
    localparam logic [2:0] C_IMM_U = 3'b100;

    // Result bus selects
    localparam logic [1:0] C_RES_ALUOUT  = 2'b00;
    localparam logic [1:0] C_RES_MEMDATA = 2'b01;
    localparam logic [1:0] C_RES_ALU     = 2'b10;
    localparam logic [1:0] C_RES_IMM     = 2'b11;

    // ALU A operand selects
    localparam logic [1:0] C_SRCA_PC    = 2'b00;
    localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] C_SRCA_REG   = 2'b10;

    // ALU B operand selects
    localparam logic [1:0] C_SRCB_REG  = 2'b00;
    localparam logic [1:0] C_SRCB_IMM  = 2'b01;
    localparam logic [1:0] C_SRCB_FOUR = 2'b10;

    // Immediate format implied by the opcode; formats without an immediate read as I
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] fmt;
        fmt = C_IMM_I;
        case (op)
            C_OP_STORE:  fmt = C_IMM_S;
            C_OP_BRANCH: fmt = C_IMM_B;
            C_OP_JAL:    fmt = C_IMM_J;
            C_OP_LUI:    fmt = C_IMM_U;
            default:     fmt = C_IMM_I;
        endcase
        return fmt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mc_alu_decoder
// Description : Maps func3 / func7[5] to the ALU operation for register and
//               immediate arithmetic. Subtraction only exists for R-type.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] func3_i,
    input  logic       func7_b5_i,
    input  logic       is_rtype_i,
    output logic [2:0] alu_control_o
);

    // func3 selects the operation; func7[5] turns add into sub for R-type only
    always_comb begin
        alu_control_o = C_ALU_ADD;
        case (func3_i)
            3'b000:  alu_control_o = (is_rtype_i && func7_b5_i) ? C_ALU_SUB : C_ALU_ADD;
            3'b111:  alu_control_o = C_ALU_AND;
            3'b110:  alu_control_o = C_ALU_OR;
            3'b100:  alu_control_o = C_ALU_XOR;
            3'b010:  alu_control_o = C_ALU_SLT;
            default: alu_control_o = C_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Moore control FSM for the multi-cycle RV32I datapath. Drives
//               all write strobes and mux selects from the current state.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       alu_sign,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src
);

    state_t     state_q;
    state_t     state_d;
    state_t     w_state;
    logic [2:0] w_alu_dec;
    logic       w_branch_take;
    logic       w_unused_func7;

    // Only func7[5] carries meaning for the supported instructions
    assign w_unused_func7 = ^{func7[6], func7[4:0]};

    // While reset is held the outputs present FETCH, whatever the register holds
    assign w_state = rst ? S_FETCH : state_q;

    mc_alu_decoder u_alu_decoder (
        .func3_i       (func3),
        .func7_b5_i    (func7[5]),
        .is_rtype_i    (state_q == S_EXEC_R),
        .alu_control_o (w_alu_dec)
    );

    // State register; reset may land mid-instruction and always restarts at FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; DECODE dispatches on opcode, unknown opcodes act as NOP
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    C_OP_LOAD, C_OP_STORE: state_d = S_MEM_ADR;
                    C_OP_RTYPE:            state_d = S_EXEC_R;
                    C_OP_ITYPE:            state_d = S_EXEC_I;
                    C_OP_BRANCH:           state_d = S_BRANCH;
                    C_OP_JAL:              state_d = S_JAL;
                    C_OP_JALR:             state_d = S_JALR;
                    C_OP_LUI:              state_d = S_LUI;
                    default:               state_d = S_FETCH;
                endcase
            end
            S_MEM_ADR:   state_d = (op == C_OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_EXEC_R:    state_d = S_ALU_WB;
            S_EXEC_I:    state_d = S_ALU_WB;
            S_JAL:       state_d = S_ALU_WB;
            S_JALR:      state_d = S_JALR_PC;
            default:     state_d = S_FETCH;
        endcase
    end

    // Branch condition from the flags of rs1 - rs2
    always_comb begin
        w_branch_take = 1'b0;
        case (func3)
            3'b000:  w_branch_take = zero;
            3'b001:  w_branch_take = !zero;
            3'b100:  w_branch_take = alu_sign;
            3'b101:  w_branch_take = !alu_sign;
            default: w_branch_take = 1'b0;
        endcase
    end

    // Moore output decode, with strobes suppressed for as long as reset is held
    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = C_RES_ALUOUT;
        alu_src_a   = C_SRCA_PC;
        alu_src_b   = C_SRCB_REG;
        alu_control = C_ALU_ADD;
        imm_src     = imm_src_of(op);
        case (w_state)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = C_SRCB_FOUR;
                result_src = C_RES_ALU;
                imm_src    = C_IMM_I;
            end
            S_DECODE: begin
                alu_src_a = C_SRCA_OLDPC;
                alu_src_b = C_SRCB_IMM;
            end
            S_MEM_ADR: begin
                alu_src_a = C_SRCA_REG;
                alu_src_b = C_SRCB_IMM;
            end
            S_MEM_READ: begin
                adr_src = 1'b1;
            end
            S_MEM_WB: begin
                result_src = C_RES_MEMDATA;
                reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a   = C_SRCA_REG;
                alu_src_b   = C_SRCB_REG;
                alu_control = w_alu_dec;
            end
            S_EXEC_I: begin
                alu_src_a   = C_SRCA_REG;
                alu_src_b   = C_SRCB_IMM;
                alu_control = w_alu_dec;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = C_SRCA_REG;
                alu_src_b   = C_SRCB_REG;
                alu_control = C_ALU_SUB;
                pc_write    = w_branch_take;
            end
            S_JAL: begin
                alu_src_a = C_SRCA_OLDPC;
                alu_src_b = C_SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_src_a  = C_SRCA_OLDPC;
                alu_src_b  = C_SRCB_FOUR;
                result_src = C_RES_ALU;
                reg_write  = 1'b1;
            end
            S_JALR_PC: begin
                alu_src_a  = C_SRCA_REG;
                alu_src_b  = C_SRCB_IMM;
                result_src = C_RES_ALU;
                pc_write   = 1'b1;
            end
            S_LUI: begin
                result_src = C_RES_IMM;
                reg_write  = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule
`default_nettype wire
